i2c_wbm_bridge: RTL

Parametrised byte-stream to Wishbone master bridge that sits on the host side of `i2c_slave`. It turns I2C write/read byte sequences into coalesced Wishbone accesses. Features:
- configurable address-header length;
- byte-lane addressing across any power-of-two data width;
- bus-cycle timeout;
- sticky error reporting.

The byte-stream ports let the same bridge serve other byte transports (SPI, UART) later.

---
 rtl/i2c_wbm_bridge.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_wbm_bridge.sv
// Byte-stream to Wishbone master bridge: an address header followed by write
// bytes or read requests is turned into word-wide Wishbone accesses.
module i2c_wbm_bridge #(
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned ADDR_BYTES    = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  input  logic                       bus_addressed,
  output logic [WB_ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [WB_DATA_WIDTH-1:0]   wb_dat_i,
  output logic                       wb_we_o,
  output logic [WB_DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                       wb_stb_o,
  output logic                       wb_cyc_o,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i,
  input  logic                       err_clear,
  output logic                       err_flag,
  output logic                       busy
);

  localparam int unsigned LANES = WB_DATA_WIDTH / 8;
  localparam int unsigned LB    = $clog2(LANES);
  localparam int unsigned LBW   = (LB == 0) ? 1 : LB;
  localparam int unsigned AW    = ADDR_BYTES * 8;
  localparam logic [LBW-1:0]           LAST_LANE = LBW'(LANES - 1);
  localparam logic [WB_ADDR_WIDTH-1:0] LANE_MASK = WB_ADDR_WIDTH'(LANES - 1);
  localparam logic [15:0]              TMO_LAST  = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [1:0]               HDR_LAST  = 2'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, HEADER, WR_COLLECT, WR_BUS, RD_BUS, RD_SEND
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               hcnt_q, hcnt_d;
  logic [AW-1:0]            shadow_q, shadow_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic                     last_q, last_d;
  logic [15:0]              tmo_q, tmo_d;
  logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [LANES-1:0]         sel_q, sel_d;
  logic                     we_q, we_d;
  logic                     cyc_q, cyc_d;
  logic                     s_tready_q, s_tready_d;
  logic                     m_tvalid_q, m_tvalid_d;
  logic [7:0]               m_tdata_q, m_tdata_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;
  logic                     err_set;

  logic [LBW-1:0]           lane_c, lane_nxt_c;
  logic [WB_ADDR_WIDTH-1:0] word_adr_c;
  logic                     s_hs_c, timeout_c, done_c, fail_c;

  assign lane_c     = LBW'(addr_q) & LAST_LANE;
  assign lane_nxt_c = LBW'(lane_c + 1'b1) & LAST_LANE;
  assign word_adr_c = WB_ADDR_WIDTH'(addr_q) & ~LANE_MASK;
  assign s_hs_c     = s_axis_tvalid & s_tready_q;
  assign timeout_c  = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
  // An err alongside ack is treated as an error.
  assign fail_c     = wb_err_i | timeout_c;
  assign done_c     = wb_ack_i | fail_c;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      shadow_q   <= '0;
      addr_q     <= '0;
      last_q     <= 1'b0;
      tmo_q      <= '0;
      rdata_q    <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      shadow_q   <= shadow_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      tmo_q      <= tmo_d;
      rdata_q    <= rdata_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    shadow_d   = shadow_q;
    addr_d     = addr_q;
    last_d     = last_q;
    rdata_d    = rdata_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    err_set    = 1'b0;
    // Counter restarts from zero each time cyc rises.
    tmo_d      = cyc_q ? tmo_q + 16'd1 : '0;

    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          state_d = HEADER;
          hcnt_d  = '0;
        end else if (m_axis_tready && bus_addressed) begin
          state_d = RD_BUS;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = '1;
          adr_d   = word_adr_c;
        end
      end
      HEADER: begin
        if (s_hs_c) begin
          shadow_d = AW'({shadow_q, s_axis_tdata});
          hcnt_d   = hcnt_q + 2'd1;
          if (hcnt_q == HDR_LAST) begin
            addr_d  = AW'({shadow_q, s_axis_tdata});
            sel_d   = '0;
            dat_d   = '0;
            state_d = s_axis_tlast ? IDLE : WR_COLLECT;
          end else if (s_axis_tlast) begin
            state_d = IDLE;
          end
        end
      end
      WR_COLLECT: begin
        if (s_hs_c) begin
          dat_d  = dat_q | (WB_DATA_WIDTH'(s_axis_tdata) << {lane_c, 3'b000});
          sel_d  = sel_q | (LANES'(1) << lane_c);
          addr_d = addr_q + AW'(1);
          adr_d  = word_adr_c;
          last_d = s_axis_tlast;
          if ((lane_c == LAST_LANE) || s_axis_tlast) begin
            state_d = WR_BUS;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
          end
        end
      end
      WR_BUS: begin
        if (done_c) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          dat_d   = '0;
          err_set = fail_c;
          state_d = last_q ? IDLE : WR_COLLECT;
        end
      end
      RD_BUS: begin
        if (done_c) begin
          rdata_d    = fail_c ? '1 : wb_dat_i;
          cyc_d      = 1'b0;
          sel_d      = '0;
          err_set    = fail_c;
          m_tvalid_d = 1'b1;
          m_tdata_d  = 8'(rdata_d >> {lane_c, 3'b000});
          state_d    = RD_SEND;
        end
      end
      RD_SEND: begin
        // Abort wins: the byte on offer in an aborting cycle counts as unsent.
        if (s_axis_tvalid || !bus_addressed) begin
          m_tvalid_d = 1'b0;
          state_d    = IDLE;
        end else if (m_axis_tready) begin
          addr_d = addr_q + AW'(1);
          if (lane_c == LAST_LANE) begin
            m_tvalid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            m_tdata_d = 8'(rdata_q >> {lane_nxt_c, 3'b000});
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_tready_d = (state_d == HEADER) || (state_d == WR_COLLECT);
    busy_d     = (state_d != IDLE);
    err_d      = err_set | (err_q & ~err_clear);
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign wb_we_o       = we_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign err_flag      = err_q;
  assign busy          = busy_q;

endmodule
